// File: rtl/lifo_frame_reverser_pkg.sv
// lifo_frame_reverser_pkg: shared LIFO geometry and the frame-reverser FSM state type
package lifo_frame_reverser_pkg;
    localparam int LIFO_DEPTH = 16;
    localparam int LIFO_WIDTH = 16;
    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;
endpackage

// File: rtl/lifo_frame_reverser_rev_out_skid.sv
// rev_out_skid: 2-entry {data,last} output buffer fed by LIFO read data, drained by a valid/ready sink
//   wr_en/wr_data/wr_last : capture strobe (registered pop) and the word/last tag being written
//   m_valid/m_ready/m_data/m_last : downstream stream port, head entry held stable while stalled
//   occupancy             : number of stored entries (0..2)
module rev_out_skid #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_last,
    input  logic             m_ready,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    output logic [1:0]       occupancy
);
    logic [WIDTH:0] mem [2];
    logic           rd_ptr;
    logic           wr_ptr;
    logic           deq;

    assign m_valid          = occupancy != 2'd0;
    assign {m_last, m_data} = mem[rd_ptr];
    assign deq              = m_valid && m_ready;

    // Writes never land on the head slot while it is valid: the producer's credit keeps occupancy <= 2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0]    <= '0;
            mem[1]    <= '0;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            occupancy <= 2'd0;
        end else begin
            if (wr_en)
                mem[wr_ptr] <= {wr_last, wr_data};
            wr_ptr    <= wr_ptr ^ wr_en;
            rd_ptr    <= rd_ptr ^ deq;
            occupancy <= occupancy + {1'b0, wr_en} - {1'b0, deq};
        end
    end
endmodule

// File: rtl/lifo_frame_reverser.sv
// lifo_frame_reverser: pushes an input frame into an external LIFO, then pops it out in reverse order
//   s_valid/s_ready/s_data/s_last        : input frame stream (held off while draining)
//   m_valid/m_ready/m_data/m_last/m_trunc : reversed output stream; m_trunc marks a frame longer than DEPTH
//   lifo_push/lifo_din/lifo_pop/lifo_dout : LIFO port, read data valid the cycle after a pop
//   lifo_empty/lifo_full                  : LIFO flags, informational only (cnt governs push/pop)
//   busy : not IDLE;  ovf_err : pulse on the first dropped beat of a frame
module lifo_frame_reverser
    import lifo_frame_reverser_pkg::*;
#(
    parameter int WIDTH = LIFO_WIDTH,
    parameter int DEPTH = LIFO_DEPTH,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    output logic             m_trunc,
    output logic             lifo_push,
    output logic             lifo_pop,
    output logic [WIDTH-1:0] lifo_din,
    input  logic [WIDTH-1:0] lifo_dout,
    input  logic             lifo_empty,
    input  logic             lifo_full,
    output logic             busy,
    output logic             ovf_err
);
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       occ;
    logic             pop_q;
    logic             last_q;
    logic             trunc;
    logic             acc;
    logic             drop;
    logic             credit;

    // Credit counts the skid slot freed by this cycle's handshake, so a full-rate drain keeps one pop
    // in flight while the head word leaves.
    always_comb begin
        state_nxt = state;
        s_ready   = !rst && state != DRAIN;
        acc       = s_valid && s_ready;
        lifo_push = acc && cnt < CNT_W'(DEPTH);
        drop      = acc && cnt == CNT_W'(DEPTH);
        ovf_err   = drop && !trunc;
        credit    = {1'b0, occ} + {2'b0, pop_q} - {2'b0, m_valid && m_ready} < 3'd2;
        lifo_pop  = state == DRAIN && cnt != '0 && credit;
        busy      = state != IDLE;
        if (state == IDLE && acc)
            state_nxt = s_last ? DRAIN : FILL;
        else if (state == FILL && acc && s_last)
            state_nxt = DRAIN;
        else if (state == DRAIN && cnt == '0 && !pop_q && occ == 2'd0)
            state_nxt = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            pop_q  <= 1'b0;
            last_q <= 1'b0;
            trunc  <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt + CNT_W'(lifo_push) - CNT_W'(lifo_pop);
            pop_q  <= lifo_pop;
            last_q <= lifo_pop && cnt == CNT_W'(1);
            trunc  <= state_nxt == IDLE ? 1'b0 : trunc | drop;
        end
    end

    assign lifo_din = s_data;
    assign m_trunc  = m_valid && trunc;

    rev_out_skid #(.WIDTH(WIDTH)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (pop_q),
        .wr_data   (lifo_dout),
        .wr_last   (last_q),
        .m_ready   (m_ready),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_last    (m_last),
        .occupancy (occ)
    );
endmodule
